regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-side front end for the CPU's 4 x 16-bit register file: collects register writeback requests from the ALU and from the load path, buffers them in a small in-order FIFO, and drains them one per cycle onto the register file's write port. It sits between the execute/memory stages and the register file's write inputs. It also drives per-register pending flags that decode uses to stall on read-after-write hazards.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2.
- DATA_W, 16, write data width.
- ADDR_W, 2, register index width (4 registers; register 0 reads as zero).
- Clock  in  1  rising-edge clock.
- ResetN  in  1  asynchronous reset, active-low.
- AluValid  in  1  ALU writeback request.
- AluRd  in  ADDR_W  ALU destination register.
- AluData  in  DATA_W  ALU result.
- AluReady  out  1  ALU request accepted this cycle when high together with AluValid.
- MemValid  in  1  load writeback request.
- MemRd  in  ADDR_W  load destination register.
- MemData  in  DATA_W  load data.
- MemReady  out  1  load request accepted this cycle when high together with MemValid.
- WbEnable  in  1  drain permission; low pauses draining.
- RD  out  ADDR_W  register file write address.
- WriteData  out  DATA_W  register file write data.
- RegWrite  out  1  register file write enable.
- Pending  out  2**ADDR_W  bit r high while a write to register r is queued or on the output.
- Count  out  clog2(DEPTH)+1  queued entries, 0..DEPTH.
- Full  out  1  Count == DEPTH.
- Empty  out  1  Count == 0.

## Operation
- Enqueue: at most one request is accepted per cycle.
  - Mem has priority over ALU.
  - MemReady = !Full.
  - AluReady = !Full && !MemValid.
  - Both readies are combinational.
- A request is accepted when it is valid and its ready is high.
- An accepted request with Rd == 0 completes its handshake but is not enqueued: Count is unchanged and no write is issued.
- Drain: on each rising edge, if WbEnable = 1 and the FIFO held at least one entry before that edge, the head is popped into the RD/WriteData output registers and RegWrite is set to 1. Otherwise RegWrite is set to 0; RD and WriteData keep their values.
- Writes leave in acceptance order. There is no bypass: a request accepted into an empty FIFO is not popped on the same edge.
- Simultaneous enqueue and pop: Count is unchanged and both pointers advance.
  - When Full, no enqueue is possible, so a pop on that edge frees one slot for the following cycle.
- Pointers wrap modulo DEPTH.
- Pending[r], for r != 0, is the OR of:
  - every valid FIFO entry whose Rd == r;
  - (RegWrite && RD == r).
- Pending[0] = 0 always.
- Pending is combinational from state.
- Reset (asynchronous, any time): pointers = 0, Count = 0, Empty = 1, Full = 0, RegWrite = 0, RD = 0, WriteData = 0, Pending = 0. Queued entries are discarded; a write in flight on the output is cancelled. After reset, AluReady = !MemValid and MemReady = 1.

## Timing
- Latency:
  - request accepted at edge N (empty FIFO, WbEnable = 1);
  - popped at edge N+1, so RegWrite is high from N+1 to N+2;
  - register file commits at edge N+2.
- Throughput: one write per cycle sustained with WbEnable held high.
- With WbEnable = 0, entries accumulate until Full; both readies are then low.
- RegWrite is high for exactly one cycle per popped entry.
- Pending for a register drops in the cycle after its last write's RegWrite cycle, i.e. after edge N+2.

## Test plan
- Single ALU write: AluValid, AluRd=3, AluData=5 accepted at edge 1 -> RegWrite=1, RD=3, WriteData=5 during cycle 2 only; Pending[3] high from after edge 1 until edge 3.
- Priority: AluValid and MemValid both high, MemRd=2/MemData=7, AluRd=1/AluData=9 -> AluReady=0, Mem accepted first; next cycle Alu accepted; writes emerge in order (2,7) then (1,9).
- Fill/stall: WbEnable=0, enqueue 4 ALU writes to reg 1 with data 1..4 -> Full=1, Count=4, both readies 0. Raise WbEnable -> four consecutive RegWrite cycles with data 1,2,3,4; Empty=1 afterwards; pointers wrap correctly on a second fill.
- Zero-register drop: AluRd=0, AluData=0xFFFF accepted -> Count stays 0, RegWrite never asserts, Pending stays 0.
- Simultaneous at Full: Full, WbEnable=1, MemValid held -> MemReady=0 on the first cycle; after the pop, MemReady=1 and the new entry is accepted while Count stays at or returns to 4.
- Reset mid-operation: 3 entries queued and RegWrite=1, pulse ResetN low asynchronously (between edges) -> RegWrite, Count, Pending and RD/WriteData go to 0 immediately; no further writes after release.

Source files
------------

// File: rtl/regfile_writeback.sv
// Purpose: queue ALU/load writebacks in order and drain one per cycle to the regfile write port.
// Latency: accept at edge N, RegWrite high N+1..N+2 (no bypass through an empty queue).
// Backpressure: MemReady=!Full, AluReady=!Full&&!MemValid (load wins); WbEnable=0 pauses draining.
module regfile_writeback #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
) (
    input  logic                      Clock,
    input  logic                      ResetN,
    input  logic                      AluValid,
    input  logic [ADDR_W-1:0]         AluRd,
    input  logic [DATA_W-1:0]         AluData,
    output logic                      AluReady,
    input  logic                      MemValid,
    input  logic [ADDR_W-1:0]         MemRd,
    input  logic [DATA_W-1:0]         MemData,
    output logic                      MemReady,
    input  logic                      WbEnable,
    output logic [ADDR_W-1:0]         RD,
    output logic [DATA_W-1:0]         WriteData,
    output logic                      RegWrite,
    output logic [2**ADDR_W-1:0]      Pending,
    output logic [$clog2(DEPTH):0]    Count,
    output logic                      Full,
    output logic                      Empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Queue storage; vld_q marks occupied slots so Pending can scan them directly.
    logic [ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  vld_q;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;

    logic              mem_acc;
    logic              alu_acc;
    logic [ADDR_W-1:0] in_rd;
    logic [DATA_W-1:0] in_data;
    logic              push;
    logic              pop;

    assign Count    = count_q;
    assign Full     = (count_q == FULL_CNT);
    assign Empty    = (count_q == '0);
    assign MemReady = !Full;
    assign AluReady = !Full && !MemValid;

    assign mem_acc  = MemValid && MemReady;
    assign alu_acc  = AluValid && AluReady;
    assign in_rd    = mem_acc ? MemRd   : AluRd;
    assign in_data  = mem_acc ? MemData : AluData;

    // Writes to register 0 are handshaken but dropped: it is hardwired to zero.
    assign push     = (mem_acc || alu_acc) && (in_rd != '0);
    // Only entries present before the edge may leave, so an empty queue never bypasses.
    assign pop      = WbEnable && !Empty;

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            vld_q     <= '0;
            RegWrite  <= 1'b0;
            RD        <= '0;
            WriteData <= '0;
        end else begin
            // push and pop never target the same slot: push needs !Full, pop needs !Empty,
            // and the pointers only coincide when the queue is empty or full.
            if (push) begin
                vld_q[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
                RD            <= rd_mem[rd_ptr];
                WriteData     <= data_mem[rd_ptr];
            end
            RegWrite <= pop;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; occupancy is tracked by vld_q.
    always_ff @(posedge Clock) begin
        if (push) begin
            rd_mem[wr_ptr]   <= in_rd;
            data_mem[wr_ptr] <= in_data;
        end
    end

    // Hazard flags: any queued entry or the in-flight write targeting a register.
    always_comb begin
        Pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                Pending[rd_mem[i]] = 1'b1;
            end
        end
        if (RegWrite) begin
            Pending[RD] = 1'b1;
        end
        Pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios then random traffic against a queue model.
module tb_regfile_writeback;

    logic        Clock;
    logic        ResetN;
    logic        AluValid;
    logic [1:0]  AluRd;
    logic [15:0] AluData;
    logic        AluReady;
    logic        MemValid;
    logic [1:0]  MemRd;
    logic [15:0] MemData;
    logic        MemReady;
    logic        WbEnable;
    logic [1:0]  RD;
    logic [15:0] WriteData;
    logic        RegWrite;
    logic [3:0]  Pending;
    logic [2:0]  Count;
    logic        Full;
    logic        Empty;

    regfile_writeback #(.DEPTH(4), .DATA_W(16), .ADDR_W(2)) dut (
        .Clock(Clock), .ResetN(ResetN),
        .AluValid(AluValid), .AluRd(AluRd), .AluData(AluData), .AluReady(AluReady),
        .MemValid(MemValid), .MemRd(MemRd), .MemData(MemData), .MemReady(MemReady),
        .WbEnable(WbEnable), .RD(RD), .WriteData(WriteData), .RegWrite(RegWrite),
        .Pending(Pending), .Count(Count), .Full(Full), .Empty(Empty)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: an in-order list of queued writes plus the output register.
    typedef struct {
        logic [1:0]  rd;
        logic [15:0] data;
    } wr_t;

    wr_t         q[$];
    logic        m_we;
    logic [1:0]  m_rd;
    logic [15:0] m_data;

    int ncomp = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] pend_model();
        logic [3:0] p;
        p = '0;
        foreach (q[i]) p[q[i].rd] = 1'b1;
        if (m_we) p[m_rd] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic model_reset();
        q.delete();
        m_we   = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endtask

    task automatic idle_inputs();
        MemValid = 1'b0; MemRd = '0; MemData = '0;
        AluValid = 1'b0; AluRd = '0; AluData = '0;
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, then registered outputs after the edge.
    task automatic step(input logic mv, input logic [1:0] mrd, input logic [15:0] md,
                        input logic av, input logic [1:0] ard, input logic [15:0] ad,
                        input logic wbe);
        logic full_m, exp_mrdy, exp_ardy, acc;
        wr_t  e;
        wr_t  h;
        @(negedge Clock);
        MemValid = mv; MemRd = mrd; MemData = md;
        AluValid = av; AluRd = ard; AluData = ad;
        WbEnable = wbe;
        #1;
        full_m   = (q.size() == 4);
        exp_mrdy = !full_m;
        exp_ardy = !full_m && !mv;
        check("MemReady", 32'(MemReady), 32'(exp_mrdy));
        check("AluReady", 32'(AluReady), 32'(exp_ardy));
        check("Count",    32'(Count),    32'(q.size()));
        check("Full",     32'(Full),     32'(full_m));
        check("Empty",    32'(Empty),    32'(q.size() == 0));
        check("Pending",  32'(Pending),  32'(pend_model()));
        acc = 1'b0;
        if (mv && exp_mrdy) begin
            e.rd = mrd; e.data = md; acc = 1'b1;
        end else if (av && exp_ardy) begin
            e.rd = ard; e.data = ad; acc = 1'b1;
        end
        @(posedge Clock);
        if (wbe && q.size() > 0) begin
            h = q.pop_front();
            m_we = 1'b1; m_rd = h.rd; m_data = h.data;
        end else begin
            m_we = 1'b0;
        end
        if (acc && e.rd != 2'd0) q.push_back(e);
        #1;
        check("RegWrite",  32'(RegWrite),  32'(m_we));
        check("RD",        32'(RD),        32'(m_rd));
        check("WriteData", 32'(WriteData), 32'(m_data));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".Count"},     32'(Count),     32'd0);
        check({tag, ".Empty"},     32'(Empty),     32'd1);
        check({tag, ".Full"},      32'(Full),      32'd0);
        check({tag, ".RegWrite"},  32'(RegWrite),  32'd0);
        check({tag, ".RD"},        32'(RD),        32'd0);
        check({tag, ".WriteData"}, 32'(WriteData), 32'd0);
        check({tag, ".Pending"},   32'(Pending),   32'd0);
        check({tag, ".MemReady"},  32'(MemReady),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ResetN = 1'b0;
        WbEnable = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_reset_state("reset");
        check("reset.AluReady", 32'(AluReady), 32'd1);
        MemValid = 1'b1;
        #1;
        check("reset.AluReady_memvld", 32'(AluReady), 32'd0);
        MemValid = 1'b0;
        #10 ResetN = 1'b1;

        // Single ALU write to r3.
        step(0, 0, 0, 1, 2'd3, 16'd5, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Load beats ALU; ALU follows next cycle.
        step(1, 2'd2, 16'd7, 1, 2'd1, 16'd9, 1);
        step(0, 0, 0, 1, 2'd1, 16'd9, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Fill with draining paused, then drain; twice so the pointers wrap.
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 2'd1, 16'(i), 0);
            step(1, 2'd2, 16'hAAAA, 1, 2'd3, 16'hBBBB, 0);
            for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1);
        end

        // Register-0 writes are accepted but dropped.
        step(0, 0, 0, 1, 2'd0, 16'hFFFF, 1);
        step(1, 2'd0, 16'h1234, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Full with draining enabled and a load held.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 2'(i % 3 + 1), 16'(16'h100 + i), 0);
        step(1, 2'd3, 16'h0C0C, 0, 0, 0, 1);
        step(1, 2'd3, 16'h0C0C, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Asynchronous reset with 3 entries queued and a write in flight.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 2'd2, 16'(16'h200 + i), 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("pre_reset.RegWrite", 32'(RegWrite), 32'd1);
        check("pre_reset.Count",    32'(Count),    32'd3);
        #2;
        ResetN = 1'b0;
        WbEnable = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check_reset_state("async_reset");
        @(negedge Clock);
        #2 ResetN = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 2) == 0), 2'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)),      2'($urandom), 16'($urandom),
                 1'($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
